mc_cpu: RTL

- Multi-cycle successor to the single-cycle MIPS core. It executes the same MIPS-I subset plus halt, one instruction at a time, through a control FSM.
- Instruction and data share one external memory. Access uses a req/ready handshake, so memory may take any number of cycles.
- Block contains the internal 32x32 register file and a retired-instruction counter. It also contains an access-timeout watchdog and a sticky error/halt status.
- Sits as the CPU top, between testbench/SoC memory model and nothing else.

---
 rtl/mc_cpu.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-I subset core (add/sub/and/or/slt, addi, lw, sw, beq, j, halt) with one shared memory port.
// Latency: j 2, beq 3, R/addi 4, sw 4, lw 5, halt 2 cycles with zero-wait memory; each memory wait adds a cycle.
// Backpressure: mem_req is held with stable addr/we/wdata until mem_ready; a watchdog faults after TIMEOUT waits.
// Ports: clk/rst (async active-low); mem_* request/ready memory port; pc_out, retired, halted, error, err_code status.
module mc_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ADDR_W   = 32,
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_out,
    output logic [CNT_W-1:0]  retired,
    output logic              halted,
    output logic              error,
    output logic [1:0]        err_code
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam int         WCW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR} state_t;

    state_t          state;
    logic [31:0]     pc, ir, a_reg, b_reg, alu_out, mdr;
    logic [31:0]     regs [32];
    logic [WCW-1:0]  wait_cnt;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wb_dst;
    logic [31:0] simm, ea, alu_res, wb_val;
    logic        dec_ok, wd_expired;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign simm   = {{16{ir[15]}}, ir[15:0]};
    assign ea     = a_reg + simm;
    assign wb_dst = (op == OP_RTYPE) ? rd : rt;
    assign wb_val = (op == OP_LW) ? mdr : alu_out;

    // The wait that would make the count reach TIMEOUT is the fatal one; a ready in that cycle still wins.
    assign wd_expired = (TIMEOUT != 0) && (wait_cnt == WCW'(TIMEOUT - 1));

    always_comb begin
        dec_ok = 1'b0;
        case (op)
            OP_RTYPE: dec_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                               (funct == 6'h25) || (funct == 6'h2A);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT: dec_ok = 1'b1;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = 32'h0;
        case (funct)
            6'h20:   alu_res = a_reg + b_reg;
            6'h22:   alu_res = a_reg - b_reg;
            6'h24:   alu_res = a_reg & b_reg;
            6'h25:   alu_res = a_reg | b_reg;
            6'h2A:   alu_res = {31'h0, $signed(a_reg) < $signed(b_reg)};
            default: alu_res = 32'h0;
        endcase
    end

    // The request is a decode of the state gated by reset, so an access in flight is
    // abandoned the instant reset asserts and nothing is requested while reset is held.
    assign mem_req   = rst && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we    = mem_req && (state == S_MEM) && (op == OP_SW);
    assign mem_addr  = (state == S_MEM) ? alu_out[ADDR_W-1:0] : pc[ADDR_W-1:0];
    assign mem_wdata = b_reg;
    assign pc_out    = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= 32'h0;
            a_reg    <= 32'h0;
            b_reg    <= 32'h0;
            alu_out  <= 32'h0;
            mdr      <= 32'h0;
            wait_cnt <= '0;
            retired  <= '0;
            halted   <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 32'd4;
                        state <= S_DECODE;
                    end else if (wd_expired) begin
                        state    <= S_ERR;
                        error    <= 1'b1;
                        err_code <= 2'd3;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    a_reg <= regs[rs];
                    b_reg <= regs[rt];
                    if (!dec_ok) begin
                        state    <= S_ERR;
                        error    <= 1'b1;
                        err_code <= 2'd1;
                    end else if (op == OP_HALT) begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        retired <= retired + 1'b1;
                    end else if (op == OP_J) begin
                        pc       <= {pc[31:28], ir[25:0], 2'b00};
                        retired  <= retired + 1'b1;
                        wait_cnt <= '0;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_RTYPE: begin
                            alu_out <= alu_res;
                            state   <= S_WB;
                        end
                        OP_ADDI: begin
                            alu_out <= ea;
                            state   <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_out <= ea;
                            if (ea[1:0] != 2'b00) begin
                                state    <= S_ERR;
                                error    <= 1'b1;
                                err_code <= 2'd2;
                            end else begin
                                wait_cnt <= '0;
                                state    <= S_MEM;
                            end
                        end
                        OP_BEQ: begin
                            // pc already points past the branch, so the offset is relative to pc+4.
                            if (a_reg == b_reg) pc <= pc + {simm[29:0], 2'b00};
                            retired  <= retired + 1'b1;
                            wait_cnt <= '0;
                            state    <= S_FETCH;
                        end
                        default: begin
                            state    <= S_ERR;
                            error    <= 1'b1;
                            err_code <= 2'd1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op == OP_SW) begin
                            retired  <= retired + 1'b1;
                            wait_cnt <= '0;
                            state    <= S_FETCH;
                        end else begin
                            mdr   <= mem_rdata;
                            state <= S_WB;
                        end
                    end else if (wd_expired) begin
                        state    <= S_ERR;
                        error    <= 1'b1;
                        err_code <= 2'd3;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    if (wb_dst != 5'd0) regs[wb_dst] <= wb_val;
                    retired  <= retired + 1'b1;
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
                default: state <= state; // S_HALT / S_ERR hold until reset
            endcase
        end
    end
endmodule
